uart_ldpc_top: RTL and testbench
================================

// Module: uart_ldpc_top
// PURPOSE
//  Single-clock UART link with (16,8) LDPC-style single-error correction.
//  - Encodes an 8-bit message into a systematic 16-bit codeword and sends it as one UART frame on tx.
//  - Receives a frame on rx, computes the 8-bit syndrome, corrects up to one bit error and presents the codeword and message.
//  - Sits between host logic and the serial pins; benches normally loop rx = tx.
// PARAMETERS
//  CLKS_PER_BIT  868    clk cycles per UART bit (115200 baud at 100 MHz); even, >= 4
//  ERR_MASK      16'h0  XOR mask applied to the transmitted codeword; only used with INJECT_ERR_EN
// PORTS
//  clk                 in   1   system clock; all logic on rising edge
//  rst                 in   1   synchronous, active-high reset
//  m                   in   8   message to send; sampled on the accepted start
//  tx_start            in   1   start request; rising edge while TX idle starts a frame
//  tx                  out  1   serial output, idle high
//  tx_done             out  1   1-cycle pulse at end of the TX stop bit
//  baud_clk            out  1   free-running square wave, period CLKS_PER_BIT (observability only, never used as a clock)
//  rx                  in   1   serial input, idle high
//  rx_done             out  1   1-cycle pulse when a valid frame has been decoded
//  syndrome            out  8   syndrome of the last received word
//  message             out  8   corrected message = corrected_codeword[15:8]
//  corrected_codeword  out  16  received codeword after single-bit correction
// BEHAVIOUR
//  Reset: tx=1, tx_done=0, baud_clk=0, rx_done=0, syndrome=0, message=0, corrected_codeword=0; TX and RX FSMs go IDLE.
//  Reset asserted mid-frame aborts the frame immediately.
//  Code: c = {m, p}.
//   - Parity: p[i] = m[i] ^ m[(i+1)%8] ^ m[(i+3)%8].
//   - Check matrix: H = [P | I8].
//   - Syndrome: s[i] = r[8+i] ^ r[8+(i+1)%8] ^ r[8+(i+3)%8] ^ r[i].
//  Correction:
//   - s == 0: no change.
//   - s == 1<<i: flip parity bit r[i].
//   - s equals column j of P (bits j, j-1, j-3 mod 8 set): flip r[8+j].
//   - Any other s: pass r uncorrected.
//  baud_clk: low for the first CLKS_PER_BIT/2 cycles, high for the second half, repeating from reset.
//  TX edge detect: tx_start is registered; its prev register is cleared by rst. A start with tx_start held high through reset release is therefore accepted on the first post-reset cycle.
//  TX FSM: IDLE -> START -> DATA(16) -> STOP -> IDLE.
//   - Each state lasts CLKS_PER_BIT cycles.
//   - Data is sent LSB first (c[0] first).
//   - tx_done pulses on the last cycle of STOP.
//   - A tx_start edge while busy is ignored; m changes while busy are ignored.
//  RX synchronizer: rx passes through 2 flops before use.
//  RX FSM: IDLE -> START -> DATA -> STOP -> IDLE.
//   - IDLE -> START on a synchronized falling edge.
//   - START: sample at CLKS_PER_BIT/2. If high, it is a glitch: return to IDLE.
//   - DATA: sample 16 bits at bit centres, LSB first.
//   - STOP: sample at centre. If 1, the next cycle registers syndrome/corrected_codeword/message and pulses rx_done. If 0 (framing error), discard the frame: no rx_done, outputs hold.
//  Outputs hold their last valid values until the next valid frame.
//  Latency: frame = 18*CLKS_PER_BIT cycles; rx_done ~ 17.5*CLKS_PER_BIT + 3 cycles after tx goes low (loopback).
// CONFIGURATION
//  INJECT_ERR_EN defined: TX shifts out c ^ ERR_MASK.
//  INJECT_ERR_EN undefined: ERR_MASK is ignored and c is sent unmodified.
// STRUCTURE
//  Package uart_ldpc_pkg:
//   - CODE_N=16, MSG_K=8.
//   - Functions ldpc_encode(m) and ldpc_syndrome(r), plus ldpc_correct(r,s).
//   - TX/RX state enum typedefs.
//  Sub-module ldpc_uart_rx: synchronizer, RX FSM and decode register. TX, encoder and baud_clk stay in the top.
// TESTING
//  - m=8'hDD, tx_start high through reset release, loopback -> one frame; rx_done once; syndrome=8'h00, corrected_codeword=16'hDD88, message=8'hDD; tx_done before rx_done.
//  - m=8'hD5 -> corrected_codeword=16'hD585, message=8'hD5, syndrome=0.
//  - INJECT_ERR_EN, ERR_MASK=16'h0100, m=8'hDD -> syndrome=8'hA1, corrected_codeword=16'hDD88, message=8'hDD.
//  - INJECT_ERR_EN, ERR_MASK=16'h0008, m=8'hDD -> syndrome=8'h08, corrected 16'hDD88.
//  - tx_start held high after the frame -> no second frame; drop and re-raise -> second frame.
//  - rx forced low 1 bit then high mid-frame, or stop bit forced 0 -> no rx_done, outputs unchanged; rst mid-frame -> tx=1, FSMs idle.

Source files
------------

// File: rtl/uart_ldpc_pkg.sv
// Shared (16,8) code definitions: sizes, encoder, syndrome and single-error corrector,
// plus the TX/RX state encodings.
package uart_ldpc_pkg;

   localparam int CODE_N = 16;
   localparam int MSG_K  = 8;

   typedef enum logic [1:0] {
      TX_IDLE  = 2'd0,
      TX_START = 2'd1,
      TX_DATA  = 2'd2,
      TX_STOP  = 2'd3
   } tx_state_e;

   typedef enum logic [1:0] {
      RX_IDLE  = 2'd0,
      RX_START = 2'd1,
      RX_DATA  = 2'd2,
      RX_STOP  = 2'd3
   } rx_state_e;

   function automatic logic [CODE_N-1:0] ldpc_encode(input logic [MSG_K-1:0] m);
      logic [MSG_K-1:0] p;
      p = 8'h00;
      for (int i = 0; i < MSG_K; i++) begin
         p[i] = m[i] ^ m[(i + 1) % MSG_K] ^ m[(i + 3) % MSG_K];
      end
      return {m, p};
   endfunction

   function automatic logic [MSG_K-1:0] ldpc_syndrome(input logic [CODE_N-1:0] r);
      logic [MSG_K-1:0] s;
      s = 8'h00;
      for (int i = 0; i < MSG_K; i++) begin
         s[i] = r[8 + i] ^ r[8 + ((i + 1) % MSG_K)] ^ r[8 + ((i + 3) % MSG_K)] ^ r[i];
      end
      return s;
   endfunction

   // Message-bit columns carry three ones and parity columns one, so the two tests never overlap.
   function automatic logic [CODE_N-1:0] ldpc_correct(input logic [CODE_N-1:0] r,
                                                       input logic [MSG_K-1:0]  s);
      logic [CODE_N-1:0] c;
      logic [MSG_K-1:0]  col;
      c = r;
      for (int j = 0; j < MSG_K; j++) begin
         col = 8'h00;
         col[j] = 1'b1;
         col[(j + 7) % MSG_K] = 1'b1;
         col[(j + 5) % MSG_K] = 1'b1;
         c[8 + j] = r[8 + j] ^ (s == col);
         c[j]     = r[j] ^ (s == (8'h01 << j));
      end
      return c;
   endfunction

endpackage

// File: rtl/uart_ldpc_if.sv
// Decoded-frame bus from the UART receiver/decoder to its consumer.
interface uart_ldpc_if;
   import uart_ldpc_pkg::*;

   logic                rx_done;
   logic [MSG_K-1:0]    syndrome;
   logic [MSG_K-1:0]    message;
   logic [CODE_N-1:0]   corrected_codeword;

   modport master (output rx_done, output syndrome, output message, output corrected_codeword);
   modport slave  (input  rx_done, input  syndrome, input  message, input  corrected_codeword);

endinterface

// File: rtl/ldpc_uart_rx.sv
// UART receiver: 2-flop synchronizer, start/data/stop FSM and registered
// syndrome decode of each well-framed 16-bit word.
module ldpc_uart_rx
   import uart_ldpc_pkg::*;
#(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rx,
   uart_ldpc_if.master      dec
);

   localparam int CW = $clog2(CLKS_PER_BIT);

   rx_state_e          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [3:0]         bit_q, bit_d;
   logic [CODE_N-1:0]  sh_q, sh_d;
   logic               pend_q, pend_d;
   logic               s1_q, s2_q, prev_q;
   logic               done_q;
   logic [MSG_K-1:0]   syn_q, syn_d;
   logic [CODE_N-1:0]  cw_q, cw_d;
   logic               fall_s;

   assign fall_s = prev_q & ~s2_q;

   // Synchronizer, FSM state and decode-result registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q    <= 1'b1;
         s2_q    <= 1'b1;
         prev_q  <= 1'b1;
         state_q <= RX_IDLE;
         cnt_q   <= '0;
         bit_q   <= 4'd0;
         sh_q    <= 16'h0000;
         pend_q  <= 1'b0;
         done_q  <= 1'b0;
         syn_q   <= 8'h00;
         cw_q    <= 16'h0000;
      end else begin
         s1_q    <= rx;
         s2_q    <= s1_q;
         prev_q  <= s2_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         sh_q    <= sh_d;
         pend_q  <= pend_d;
         done_q  <= pend_q;
         syn_q   <= syn_d;
         cw_q    <= cw_d;
      end
   end

   // Next-state logic; a frame is only committed one cycle after a good stop bit.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      sh_d    = sh_q;
      pend_d  = 1'b0;
      syn_d   = syn_q;
      cw_d    = cw_q;
      if (pend_q) begin
         syn_d = ldpc_syndrome(sh_q);
         cw_d  = ldpc_correct(sh_q, ldpc_syndrome(sh_q));
      end else begin
         syn_d = syn_q;
      end
      case (state_q)
         RX_IDLE: begin
            cnt_d = '0;
            if (fall_s) begin
               state_d = RX_START;
            end else begin
               state_d = RX_IDLE;
            end
         end
         RX_START: begin
            if (cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
               cnt_d   = '0;
               bit_d   = 4'd0;
               state_d = s2_q ? RX_IDLE : RX_DATA;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RX_DATA: begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d = '0;
               sh_d  = {s2_q, sh_q[CODE_N-1:1]};
               if (bit_q == 4'd15) begin
                  state_d = RX_STOP;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         RX_STOP: begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               pend_d  = s2_q;
               state_d = RX_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = RX_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   assign dec.rx_done            = done_q;
   assign dec.syndrome           = syn_q;
   assign dec.corrected_codeword = cw_q;
   assign dec.message            = cw_q[CODE_N-1:MSG_K];

endmodule

// File: rtl/uart_ldpc_top.sv
// UART link with (16,8) single-error-correcting code: encoder, TX FSM and baud_clk here,
// receive/decode in ldpc_uart_rx. Define INJECT_ERR_EN to XOR ERR_MASK into every sent codeword.
module uart_ldpc_top
   import uart_ldpc_pkg::*;
#(
   parameter int           CLKS_PER_BIT = 868,
   parameter logic [15:0]  ERR_MASK     = 16'h0000
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [7:0]   m,
   input  logic         tx_start,
   output logic         tx,
   output logic         tx_done,
   output logic         baud_clk,
   input  logic         rx,
   output logic         rx_done,
   output logic [7:0]   syndrome,
   output logic [7:0]   message,
   output logic [15:0]  corrected_codeword
);

   localparam int CW = $clog2(CLKS_PER_BIT);

`ifdef INJECT_ERR_EN
   localparam logic [15:0] TX_MASK = ERR_MASK;
`else
   localparam logic [15:0] TX_MASK = ERR_MASK & 16'h0000;
`endif

   tx_state_e          state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [3:0]         bit_q, bit_d;
   logic [CODE_N-1:0]  sh_q, sh_d;
   logic               tx_q, tx_d;
   logic               done_q, done_d;
   logic               start_prev_q;
   logic [CW-1:0]      baud_cnt_q, baud_cnt_d;
   logic               baud_q, baud_d;
   logic               start_edge_s;

   assign start_edge_s = tx_start & ~start_prev_q;

   // TX FSM, shift register, edge-detect and baud divider registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= TX_IDLE;
         cnt_q        <= '0;
         bit_q        <= 4'd0;
         sh_q         <= 16'h0000;
         tx_q         <= 1'b1;
         done_q       <= 1'b0;
         start_prev_q <= 1'b0;
         baud_cnt_q   <= '0;
         baud_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         sh_q         <= sh_d;
         tx_q         <= tx_d;
         done_q       <= done_d;
         start_prev_q <= tx_start;
         baud_cnt_q   <= baud_cnt_d;
         baud_q       <= baud_d;
      end
   end

   // TX next state; tx_d tracks state_d so the pin changes together with the state.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      bit_d      = bit_q;
      sh_d       = sh_q;
      tx_d       = tx_q;
      done_d     = 1'b0;
      baud_cnt_d = (baud_cnt_q == CW'(CLKS_PER_BIT - 1)) ? '0 : baud_cnt_q + CW'(1);
      baud_d     = (baud_cnt_d >= CW'(CLKS_PER_BIT / 2));
      case (state_q)
         TX_IDLE: begin
            tx_d  = 1'b1;
            cnt_d = '0;
            if (start_edge_s) begin
               state_d = TX_START;
               sh_d    = ldpc_encode(m) ^ TX_MASK;
               tx_d    = 1'b0;
            end else begin
               state_d = TX_IDLE;
            end
         end
         TX_START: begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               bit_d   = 4'd0;
               state_d = TX_DATA;
               tx_d    = sh_q[0];
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         TX_DATA: begin
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d = '0;
               if (bit_q == 4'd15) begin
                  state_d = TX_STOP;
                  tx_d    = 1'b1;
               end else begin
                  bit_d = bit_q + 4'd1;
                  sh_d  = {1'b0, sh_q[CODE_N-1:1]};
                  tx_d  = sh_q[1];
               end
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         TX_STOP: begin
            done_d = (cnt_q == CW'(CLKS_PER_BIT - 2));
            if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
               cnt_d   = '0;
               state_d = TX_IDLE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: begin
            state_d = TX_IDLE;
            tx_d    = 1'b1;
         end
      endcase
   end

   assign tx       = tx_q;
   assign tx_done  = done_q;
   assign baud_clk = baud_q;

   uart_ldpc_if dec_if ();

   ldpc_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
      .clk (clk),
      .rst (rst),
      .rx  (rx),
      .dec (dec_if)
   );

   assign rx_done            = dec_if.rx_done;
   assign syndrome           = dec_if.syndrome;
   assign message            = dec_if.message;
   assign corrected_codeword = dec_if.corrected_codeword;

endmodule

// File: tb/tb_uart_ldpc_top.sv
// Scoreboard bench for uart_ldpc_top: loopback and bench-built frames, correction
// vectors, glitch/framing rejection, tx_start edge rules and mid-frame reset.
module tb_uart_ldpc_top;
   localparam int CPB = 8;
`ifdef INJECT_ERR_EN
   localparam logic [15:0] MASK     = 16'h0100;
   localparam logic [7:0]  LOOP_SYN = 8'hA1;
`else
   localparam logic [15:0] MASK     = 16'h0100;
   localparam logic [7:0]  LOOP_SYN = 8'h00;
`endif

   typedef struct packed {
      logic [7:0]  syn;
      logic [15:0] cw;
      logic        loop;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, tx_start, tx, tx_done, baud_clk, rx, rx_done;
   logic        loop_en, rx_drv;
   logic [7:0]  m, syndrome, message;
   logic [15:0] corrected_codeword;

   int   total = 0;
   int   bad = 0;
   int   tx_done_cnt = 0;
   logic tx_done_seen = 1'b0;
   exp_t exp_q[$];

   always #5 clk = ~clk;
   assign rx = loop_en ? tx : rx_drv;

   uart_ldpc_top #(.CLKS_PER_BIT(CPB), .ERR_MASK(MASK)) dut (
      .clk(clk), .rst(rst), .m(m), .tx_start(tx_start), .tx(tx), .tx_done(tx_done),
      .baud_clk(baud_clk), .rx(rx), .rx_done(rx_done), .syndrome(syndrome),
      .message(message), .corrected_codeword(corrected_codeword)
   );

   uart_ldpc_if mon_if ();
   assign mon_if.rx_done            = rx_done;
   assign mon_if.syndrome           = syndrome;
   assign mon_if.message            = message;
   assign mon_if.corrected_codeword = corrected_codeword;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic wait_drain(input int budget);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < budget) begin
         cyc(1);
         k++;
      end
      chk("drain_timeout", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic send_frame(input logic [15:0] w, input logic stop_bit);
      rx_drv = 1'b0;
      cyc(CPB);
      for (int i = 0; i < 16; i++) begin
         rx_drv = w[i];
         cyc(CPB);
      end
      rx_drv = stop_bit;
      cyc(CPB);
      rx_drv = 1'b1;
      cyc(CPB);
   endtask

   task automatic push(input logic [7:0] s, input logic [15:0] c, input logic lp);
      exp_t e;
      e.syn  = s;
      e.cw   = c;
      e.loop = lp;
      exp_q.push_back(e);
   endtask

   // Monitor: every rx_done pops one expected frame; rx_done with nothing queued is an error.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (tx_done) begin
            tx_done_cnt++;
            tx_done_seen = 1'b1;
         end
         if (mon_if.rx_done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_rx_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("syndrome", mon_if.syndrome, e.syn);
               chk("codeword", mon_if.corrected_codeword, e.cw);
               chk("message", mon_if.message, e.cw[15:8]);
               if (e.loop) chk("tx_done_before_rx_done", tx_done_seen, 1'b1);
            end
            tx_done_seen = 1'b0;
         end
      end
   end

   initial begin
      rst = 1'b1; tx_start = 1'b0; m = 8'h00; loop_en = 1'b1; rx_drv = 1'b1;
      cyc(3);
      chk("rst_tx", tx, 1'b1);
      chk("rst_tx_done", tx_done, 1'b0);
      chk("rst_baud", baud_clk, 1'b0);
      chk("rst_rx_done", rx_done, 1'b0);
      chk("rst_syndrome", syndrome, 8'h00);
      chk("rst_message", message, 8'h00);
      chk("rst_codeword", corrected_codeword, 16'h0000);
      rst = 1'b0;
      for (int n = 1; n <= 2 * CPB; n++) begin
         cyc(1);
         chk("baud_clk", baud_clk, ((n % CPB) >= (CPB / 2)) ? 1'b1 : 1'b0);
      end
      chk("idle_tx", tx, 1'b1);

      // tx_start high through reset release: exactly one frame
      rst = 1'b1; m = 8'hDD; tx_start = 1'b1;
      cyc(2);
      push(LOOP_SYN, 16'hDD88, 1'b1);
      rst = 1'b0;
      wait_drain(400);
      cyc(30 * CPB);
      chk("held_start_frames", tx_done_cnt, 1);

      // Drop and re-raise: second frame; m changes while busy are ignored
      tx_start = 1'b0; cyc(2);
      m = 8'hD5; tx_start = 1'b1; cyc(3);
      m = 8'h00;
      push(LOOP_SYN, 16'hD585, 1'b1);
      wait_drain(400);
      cyc(20);
      chk("second_frame", tx_done_cnt, 2);

      // Bench-built frames with injected errors
      loop_en = 1'b0; rx_drv = 1'b1; cyc(CPB);
      push(8'h08, 16'hDD88, 1'b0); send_frame(16'hDD80, 1'b1); wait_drain(50);
      push(8'hA1, 16'hDD88, 1'b0); send_frame(16'hDC88, 1'b1); wait_drain(50);
      push(8'hD0, 16'hDD88, 1'b0); send_frame(16'h5D88, 1'b1); wait_drain(50);
      push(8'h03, 16'hDD8B, 1'b0); send_frame(16'hDD8B, 1'b1); wait_drain(50);

      // Start glitch and framing error: no rx_done, outputs hold
      rx_drv = 1'b0; cyc(2); rx_drv = 1'b1; cyc(4 * CPB);
      send_frame(16'h1234, 1'b0);
      cyc(3 * CPB);
      chk("hold_syndrome", syndrome, 8'h03);
      chk("hold_codeword", corrected_codeword, 16'hDD8B);
      chk("hold_message", message, 8'hDD);

      // Reset in the middle of a loopback frame
      loop_en = 1'b1; tx_start = 1'b0; cyc(2);
      m = 8'hDD; tx_start = 1'b1; cyc(5 * CPB);
      chk("midframe_tx_low_or_data", rx_done, 1'b0);
      rst = 1'b1; tx_start = 1'b0; cyc(1);
      chk("midrst_tx", tx, 1'b1);
      chk("midrst_tx_done", tx_done, 1'b0);
      chk("midrst_syndrome", syndrome, 8'h00);
      chk("midrst_codeword", corrected_codeword, 16'h0000);
      rst = 1'b0;
      cyc(25 * CPB);
      chk("post_rst_tx", tx, 1'b1);
      chk("post_rst_frames", tx_done_cnt, 2);
      chk("post_rst_rx_done_none", corrected_codeword, 16'h0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
